// File: rtl/zynq_pkg.sv
// Shared tag-sender constants and the sender FSM state type.
// Defaults describe a 16-client tag ring with 1-bit payloads.
package zynq_pkg;

    localparam int tag_els_gp = 16;
    localparam int tag_lg_els_gp = $clog2(tag_els_gp);
    localparam int tag_max_payload_width_gp = 1;
    localparam int tag_lg_width_gp = $clog2(tag_max_payload_width_gp + 1);

    typedef enum logic [2:0] {
        ZTS_IDLE,
        ZTS_START,
        ZTS_LEN,
        ZTS_DNR,
        ZTS_NODE,
        ZTS_PAYLOAD,
        ZTS_GAP
    } zynq_tag_sender_state_e;

    // Largest of three counts; sizes the shared bit counter.
    function automatic int zts_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/zynq_tag_sender.sv
// Serialises tag commands (start, len, dnr, node, payload) LSB first.
// Define ZYNQ_TAG_SENDER_LEN_CHECK_EN to drop oversize commands and flag err_o.
module zynq_tag_sender
    import zynq_pkg::*;
#(
    parameter int els_p               = tag_els_gp,
    parameter int max_payload_width_p = tag_max_payload_width_gp,
    parameter int gap_p               = 4
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic                                     v_i,
    output logic                                     ready_and_o,
    input  logic [$clog2(els_p)-1:0]                 nodeid_i,
    input  logic                                     data_not_reset_i,
    input  logic [$clog2(max_payload_width_p+1)-1:0] len_i,
    input  logic [max_payload_width_p-1:0]           payload_i,
    output logic                                     tag_data_o,
    output logic                                     done_o,
    output logic                                     err_o
);

    localparam int NW = $clog2(els_p);
    localparam int LW = $clog2(max_payload_width_p + 1);
    localparam int SW = LW + 1 + NW + max_payload_width_p;
    localparam int CW = $clog2(zts_max3(NW, max_payload_width_p, gap_p) + 1);
    localparam bit NODE1 = (NW == 1);

    zynq_tag_sender_state_e state_q;
    logic [CW-1:0]          cnt_q;
    logic [SW-1:0]          sr_q;
    logic [LW-1:0]          len_q;
    logic                   tag_q;
    logic                   done_q;
    logic                   ready_q;

    logic [LW:0]   len_ext;
    logic          len_over;
    logic [LW-1:0] len_eff;
    logic          drop;

    assign len_ext  = {1'b0, len_i};
    assign len_over = len_ext > (LW+1)'(max_payload_width_p);
    assign len_eff  = len_over ? LW'(max_payload_width_p) : len_i;

`ifdef ZYNQ_TAG_SENDER_LEN_CHECK_EN
    logic err_q;

    assign drop  = len_over;
    assign err_o = err_q;

    // Remember any oversize command until the next reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (state_q == ZTS_IDLE && v_i && len_over) begin
            err_q <= 1'b1;
        end
    end
`else
    assign drop  = 1'b0;
    assign err_o = 1'b0;
`endif

    assign tag_data_o  = tag_q;
    assign done_o      = done_q;
    assign ready_and_o = ready_q;

    // Packet sequencer: one stream bit per cycle, outputs registered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ZTS_GAP;
            cnt_q   <= CW'(gap_p);
            sr_q    <= '0;
            len_q   <= '0;
            tag_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ZTS_IDLE: begin
                    tag_q <= 1'b0;
                    if (v_i && !drop) begin
                        state_q <= ZTS_START;
                        tag_q   <= 1'b1;
                        ready_q <= 1'b0;
                        sr_q    <= {payload_i, nodeid_i,
                                    data_not_reset_i, len_eff};
                        len_q   <= len_eff;
                    end
                end
                ZTS_START: begin
                    state_q <= ZTS_LEN;
                    cnt_q   <= CW'(LW);
                    tag_q   <= sr_q[0];
                    sr_q    <= sr_q >> 1;
                end
                ZTS_LEN: begin
                    tag_q <= sr_q[0];
                    sr_q  <= sr_q >> 1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= ZTS_DNR;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ZTS_DNR: begin
                    state_q <= ZTS_NODE;
                    cnt_q   <= CW'(NW);
                    tag_q   <= sr_q[0];
                    sr_q    <= sr_q >> 1;
                    done_q  <= NODE1 && (len_q == '0);
                end
                ZTS_NODE: begin
                    if (cnt_q == CW'(1)) begin
                        if (len_q == '0) begin
                            state_q <= ZTS_GAP;
                            cnt_q   <= CW'(gap_p);
                            tag_q   <= 1'b0;
                        end else begin
                            state_q <= ZTS_PAYLOAD;
                            cnt_q   <= CW'(len_q);
                            tag_q   <= sr_q[0];
                            sr_q    <= sr_q >> 1;
                            done_q  <= (len_q == LW'(1));
                        end
                    end else begin
                        cnt_q  <= cnt_q - CW'(1);
                        tag_q  <= sr_q[0];
                        sr_q   <= sr_q >> 1;
                        done_q <= (cnt_q == CW'(2)) && (len_q == '0);
                    end
                end
                ZTS_PAYLOAD: begin
                    if (cnt_q == CW'(1)) begin
                        state_q <= ZTS_GAP;
                        cnt_q   <= CW'(gap_p);
                        tag_q   <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - CW'(1);
                        tag_q  <= sr_q[0];
                        sr_q   <= sr_q >> 1;
                        done_q <= (cnt_q == CW'(2));
                    end
                end
                ZTS_GAP: begin
                    tag_q <= 1'b0;
                    if (cnt_q == CW'(1)) begin
                        state_q <= ZTS_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= ZTS_GAP;
                    cnt_q   <= CW'(gap_p);
                    tag_q   <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zynq_tag_sender.sv
// Directed bench for zynq_tag_sender: vector table plus corner sequences.
// A second instance with 2-bit payloads exercises length overflow.
module tb_zynq_tag_sender;
    import zynq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v1, rdy1, dnr1, tag1, done1, err1;
    logic [3:0] node1;
    logic [0:0] len1, pay1;

    logic       v2, rdy2, dnr2, tag2, done2, err2;
    logic [3:0] node2;
    logic [1:0] len2, pay2;

    int n_cmp = 0;
    int n_bad = 0;

    zynq_tag_sender u_dut (
        .clk_i(clk), .reset_i(rst), .v_i(v1), .ready_and_o(rdy1),
        .nodeid_i(node1), .data_not_reset_i(dnr1), .len_i(len1),
        .payload_i(pay1), .tag_data_o(tag1), .done_o(done1), .err_o(err1)
    );

    zynq_tag_sender #(.max_payload_width_p(2)) u_dut2 (
        .clk_i(clk), .reset_i(rst), .v_i(v2), .ready_and_o(rdy2),
        .nodeid_i(node2), .data_not_reset_i(dnr2), .len_i(len2),
        .payload_i(pay2), .tag_data_o(tag2), .done_o(done2), .err_o(err2)
    );

    typedef struct {
        logic [3:0]  node;
        logic        dnr;
        logic [1:0]  len;
        logic [1:0]  pay;
        logic [15:0] bits;
        int          n;
    } vec_t;

    vec_t vecs[6];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic cur_tag(input bit sel);
        return sel ? tag2 : tag1;
    endfunction

    function automatic logic cur_rdy(input bit sel);
        return sel ? rdy2 : rdy1;
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? done2 : done1;
    endfunction

    task automatic drive(input bit sel, input logic v, input logic [3:0] node,
                         input logic dnr, input logic [1:0] len,
                         input logic [1:0] pay);
        if (!sel) begin
            v1 = v; node1 = node; dnr1 = dnr; len1 = len[0]; pay1 = pay[0];
        end else begin
            v2 = v; node2 = node; dnr2 = dnr; len2 = len; pay2 = pay;
        end
    endtask

    task automatic wait_ready(input bit sel, input string name);
        int t;
        t = 0;
        while (!cur_rdy(sel) && t < 50) begin
            step();
            t++;
        end
        check({name, "_ready_wait"}, 32'(cur_rdy(sel)), 32'd1);
    endtask

    task automatic collect(input bit sel, input int n,
                           output logic [15:0] bits,
                           output logic [15:0] dn);
        bits = '0;
        dn   = '0;
        for (int i = 0; i < n; i++) begin
            bits[i] = cur_tag(sel);
            dn[i]   = cur_done(sel);
            step();
        end
    endtask

    task automatic run_pkt(input bit sel, input string name,
                           input logic [3:0] node, input logic dnr,
                           input logic [1:0] len, input logic [1:0] pay,
                           input logic [15:0] exp, input int n);
        logic [15:0] bits, dn, dexp;
        logic tz, rz;
        wait_ready(sel, name);
        drive(sel, 1'b1, node, dnr, len, pay);
        step();
        drive(sel, 1'b0, ~node, ~dnr, ~len, ~pay);
        collect(sel, n, bits, dn);
        dexp = '0;
        dexp[n-1] = 1'b1;
        check({name, "_bits"}, 32'(bits), 32'(exp));
        check({name, "_done"}, 32'(dn), 32'(dexp));
        tz = 1'b0;
        rz = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tz |= cur_tag(sel);
            rz |= cur_rdy(sel);
            step();
        end
        check({name, "_gap_tag"}, 32'({tz, rz}), 32'd0);
        check({name, "_ready_after"}, 32'(cur_rdy(sel)), 32'd1);
    endtask

    initial begin
        logic [15:0] bits, dn;
        logic tz;
        int c;

        vecs[0] = '{4'h1, 1'b1, 2'd1, 2'd1, 16'h008F, 8};
        vecs[1] = '{4'h0, 1'b0, 2'd0, 2'd0, 16'h0001, 7};
        vecs[2] = '{4'hA, 1'b1, 2'd1, 2'd0, 16'h0057, 8};
        vecs[3] = '{4'hF, 1'b0, 2'd0, 2'd0, 16'h0079, 7};
        vecs[4] = '{4'h5, 1'b0, 2'd1, 2'd1, 16'h00AB, 8};
        vecs[5] = '{4'h8, 1'b1, 2'd0, 2'd1, 16'h0045, 7};

        drive(1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0);

        // reset, then four gap cycles before ready
        rst = 1'b1;
        repeat (3) step();
        check("in_reset", 32'({tag1, rdy1, done1, err1}), 32'd0);
        rst = 1'b0;
        c = 0;
        tz = 1'b0;
        while (!rdy1 && c < 20) begin
            tz |= tag1;
            c++;
            step();
        end
        check("reset_gap_cycles", 32'(c), 32'd4);
        check("reset_gap_tag", 32'(tz), 32'd0);

        for (int k = 0; k < 6; k++) begin
            run_pkt(1'b0, $sformatf("vec%0d", k), vecs[k].node, vecs[k].dnr,
                    vecs[k].len, vecs[k].pay, vecs[k].bits, vecs[k].n);
        end

        // back-to-back with v_i held high
        wait_ready(1'b0, "b2b");
        drive(1'b0, 1'b1, 4'h1, 1'b1, 2'd1, 2'd1);
        step();
        collect(1'b0, 8, bits, dn);
        check("b2b_first", 32'(bits), 32'h8F);
        c = 0;
        while (tag1 == 1'b0 && c < 20) begin
            c++;
            step();
        end
        check("b2b_zero_gap", 32'(c), 32'd5);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0);
        collect(1'b0, 8, bits, dn);
        check("b2b_second", 32'(bits), 32'h8F);
        check("b2b_second_done", 32'(dn), 32'h80);

        // reset in the middle of a packet
        wait_ready(1'b0, "midrst");
        drive(1'b0, 1'b1, 4'h1, 1'b1, 2'd1, 2'd1);
        step();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_outs", 32'({tag1, done1, rdy1}), 32'd0);
        c = 0;
        tz = 1'b0;
        while (!rdy1 && c < 20) begin
            tz |= tag1;
            c++;
            step();
        end
        check("midrst_gap_cycles", 32'(c), 32'd4);
        check("midrst_gap_tag", 32'(tz), 32'd0);
        run_pkt(1'b0, "after_rst", 4'h5, 1'b0, 2'd1, 2'd1, 16'h00AB, 8);

        // oversize length on the 2-bit payload instance
`ifdef ZYNQ_TAG_SENDER_LEN_CHECK_EN
        wait_ready(1'b1, "lenerr");
        drive(1'b1, 1'b1, 4'h2, 1'b1, 2'd3, 2'd3);
        step();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0);
        tz = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tz |= tag2;
            step();
        end
        check("lenerr_no_bits", 32'(tz), 32'd0);
        check("lenerr_err", 32'(err2), 32'd1);
        check("lenerr_ready", 32'(rdy2), 32'd1);
        run_pkt(1'b1, "len2", 4'h2, 1'b1, 2'd2, 2'd3, 16'h032D, 10);
        check("lenerr_sticky", 32'(err2), 32'd1);
`else
        run_pkt(1'b1, "lenclamp", 4'h2, 1'b1, 2'd3, 2'd3, 16'h032D, 10);
        check("lenclamp_err", 32'(err2), 32'd0);
`endif
        check("err_default", 32'(err1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
